data_bus_responder: RTL
=======================

Name: data_bus_responder

Overview:
- Memory-side responder for the CPU data bus (ADDR, Data_BUS_WRITE, Data_BUS_READ, CS, WR_RD); the CPU is the initiator.
- Holds a word-addressed RAM window, decodes the address and performs writes.
- Returns read data after a fixed, parameterised latency with a valid strobe.
- Flags illegal accesses in a sticky error bit and keeps access statistics for the system bench.

Parameters:
- BASE_ADDR, 32'h0000_1000, byte address of word 0 of the window.
- DEPTH, 256, number of 32-bit words; power of 2, minimum 2.
- READ_LAT, 2, clock edges from request sample to data on bus; legal range 1..4.
- ERR_DATA, 32'hDEAD_BEEF, data returned for illegal reads.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- CS  in  1  bus access request, sampled every rising edge.
- WR_RD  in  1  1 = write, 0 = read; qualified by CS.
- ADDR  in  32  byte address.
- Data_BUS_WRITE  in  32  write data from the CPU.
- Data_BUS_READ  out  32  read data to the CPU; registered.
- rd_valid  out  1  one-cycle strobe; Data_BUS_READ is new in this cycle.
- clr_err  in  1  clears bus_err.
- bus_err  out  1  sticky illegal-access flag.
- rd_count  out  16  count of legal reads; saturating.
- wr_count  out  16  count of legal writes; saturating.

Behaviour:
- Reset (asynchronous, while rst=1):
  - Data_BUS_READ=0, rd_valid=0, bus_err=0, rd_count=0, wr_count=0.
  - Read pipeline flushed.
  - RAM contents are not cleared.
- Legal access:
  - CS=1, ADDR[1:0]=0 and BASE_ADDR <= ADDR <= BASE_ADDR+4*(DEPTH-1).
  - Index = (ADDR-BASE_ADDR)>>2, log2(DEPTH) bits.
- Write (legal, WR_RD=1):
  - mem[index] <= Data_BUS_WRITE at the sampling edge.
  - wr_count+1, saturating at 16'hFFFF.
  - No change to rd_valid.
- Read (legal, WR_RD=0):
  - mem[index] is captured at the sampling edge (edge 0).
  - Data_BUS_READ updates and rd_valid=1 after edge READ_LAT; rd_valid lasts exactly 1 cycle.
  - rd_count+1, saturating.
- Pipelining:
  - One request accepted per cycle; back-to-back reads produce back-to-back rd_valid in request order.
  - Between strobes, Data_BUS_READ holds its last value.
- Read-after-write:
  - A read sampled the cycle after a write to the same index returns the new data.
  - The write is already committed at the earlier edge, so no forwarding is needed.
- Illegal access (CS=1, misaligned or out of window):
  - No RAM change; counters unchanged.
  - bus_err=1 after the sampling edge.
  - An illegal read still returns ERR_DATA with the normal READ_LAT timing and rd_valid.
- clr_err: bus_err<=0 at the edge. If an illegal access is sampled at the same edge, set wins and bus_err stays 1.
- CS=0: no access. X on ADDR/WR_RD is ignored.
- Reset mid-operation: in-flight reads are discarded, and no rd_valid appears after reset release for requests issued before reset.
- Counters freeze at 16'hFFFF and do not wrap.

Decomposition:
- Shared package bus_pkg holds:
  - BUS_WR=1'b1 and BUS_RD=1'b0.
  - Bus width constant (32).
  - Default ERR_DATA.
  - Saturating-increment function, shared with other bus peripherals.
- Sub-module rd_lat_pipe: parameterised READ_LAT-stage shift register of {valid, data[31:0]}. It has asynchronous clear on rst and is reused by future bus slaves.

Test Plan:
1. Reset value: rst pulse -> all outputs 0, no rd_valid for 10 cycles with CS=0.
2. Write then read, READ_LAT=2:
   - Stimulus: write 32'h3232_3232 to 0x1000, then a read of 0x1000 in the next cycle.
   - Required: rd_valid exactly 2 edges after the read sample with Data_BUS_READ=32'h3232_3232; wr_count=1, rd_count=1.
3. Back-to-back reads:
   - Stimulus: preload 0x1004=A1, 0x1008=B2, 0x13FC=C3; read all three on consecutive cycles.
   - Required: three consecutive rd_valid cycles carrying A1, B2, C3.
4. Illegal accesses:
   - Stimulus: read 0x1002 (misaligned), then write 0x1400 (out of window).
   - Required: the read returns 32'hDEAD_BEEF with rd_valid; bus_err=1; mem[0] unchanged; counters unchanged.
   - Stimulus: clr_err and an illegal access at the same edge. Required: bus_err stays 1.
   - Stimulus: clr_err alone. Required: bus_err=0.
5. Reset mid-operation: issue a read, assert rst 1 cycle later -> no rd_valid, Data_BUS_READ=0 after release.
6. Saturation: force rd_count to 16'hFFFE via 65534 reads, then 3 more reads -> rd_count=16'hFFFF, and data is still returned correctly.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared CPU data-bus definitions: direction codes, widths, defaults, helpers.
package bus_pkg;

  localparam int unsigned BUS_W = 32;
  localparam int unsigned CNT_W = 16;

  localparam logic BUS_WR = 1'b1;
  localparam logic BUS_RD = 1'b0;

  localparam logic [BUS_W-1:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  // One read-return beat travelling down a latency pipe
  typedef struct packed {
    logic             valid;
    logic [BUS_W-1:0] data;
  } rd_beat_t;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : CNT_W'(v + CNT_W'(1));
  endfunction

endpackage

// File: rtl/rd_lat_pipe.sv
// Fixed-latency shift register for read-return beats, cleared by rst.
module rd_lat_pipe
  import bus_pkg::*;
#(
  parameter int unsigned STAGES = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  rd_beat_t beat_i,
  output rd_beat_t beat_o
);

  rd_beat_t stage_q [STAGES];

  // Shift beats one stage per clock; reset discards everything in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= beat_i;
      for (int unsigned i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign beat_o = stage_q[STAGES-1];

endmodule

// File: rtl/data_bus_responder.sv
// Memory-side responder for the CPU data bus: RAM window, fixed read latency,
// sticky illegal-access flag and saturating access counters.
module data_bus_responder
  import bus_pkg::*;
#(
  parameter logic [BUS_W-1:0] BASE_ADDR = 32'h0000_1000,
  parameter int unsigned      DEPTH     = 256,
  parameter int unsigned      READ_LAT  = 2,
  parameter logic [BUS_W-1:0] ERR_DATA  = ERR_DATA_DEFAULT
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             CS,
  input  logic             WR_RD,
  input  logic [BUS_W-1:0] ADDR,
  input  logic [BUS_W-1:0] Data_BUS_WRITE,
  output logic [BUS_W-1:0] Data_BUS_READ,
  output logic             rd_valid,
  input  logic             clr_err,
  output logic             bus_err,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [BUS_W-1:0] mem_q [DEPTH];

  logic [29:0]      off_w_c;
  logic             aligned_c;
  logic             in_win_c;
  logic             legal_c;
  logic             illegal_c;
  logic             wr_c;
  logic             rd_req_c;
  logic             rd_legal_c;
  logic [IDX_W-1:0] idx_c;
  rd_beat_t         pipe_in_c;
  rd_beat_t         pipe_out_c;

  logic [BUS_W-1:0] rdata_q,  rdata_d;
  logic             rvalid_q, rvalid_d;
  logic             err_q,    err_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;

  // Address decode on word addresses; CS gates everything so X elsewhere is harmless
  always_comb begin
    off_w_c    = ADDR[31:2] - BASE_ADDR[31:2];
    aligned_c  = (ADDR[1:0] == 2'b00);
    in_win_c   = (ADDR[31:2] >= BASE_ADDR[31:2]) && (off_w_c < 30'(DEPTH));
    legal_c    = CS && aligned_c && in_win_c;
    illegal_c  = CS && !(aligned_c && in_win_c);
    idx_c      = off_w_c[IDX_W-1:0];
    wr_c       = legal_c && (WR_RD == BUS_WR);
    rd_req_c   = CS && (WR_RD == BUS_RD);
    rd_legal_c = legal_c && (WR_RD == BUS_RD);
    pipe_in_c.valid = rd_req_c;
    pipe_in_c.data  = '0;
    if (rd_legal_c) begin
      pipe_in_c.data = mem_q[idx_c];
    end else if (rd_req_c) begin
      pipe_in_c.data = ERR_DATA;
    end
  end

  // RAM write port; contents survive reset
  always_ff @(posedge CLK) begin
    if (wr_c) begin
      mem_q[idx_c] <= Data_BUS_WRITE;
    end
  end

  // Read data captured at the sampling edge travels READ_LAT stages
  rd_lat_pipe #(
    .STAGES (READ_LAT)
  ) u_pipe (
    .clk    (CLK),
    .rst    (rst),
    .beat_i (pipe_in_c),
    .beat_o (pipe_out_c)
  );

  // Next-state for output data, strobe, sticky error and counters
  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = pipe_out_c.valid;
    err_d    = err_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (pipe_out_c.valid) begin
      rdata_d = pipe_out_c.data;
    end
    if (clr_err) begin
      err_d = 1'b0;
    end
    if (illegal_c) begin
      err_d = 1'b1;
    end
    if (rd_legal_c) begin
      rd_cnt_d = sat_inc(rd_cnt_q);
    end
    if (wr_c) begin
      wr_cnt_d = sat_inc(wr_cnt_q);
    end
  end

  // State registers
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign Data_BUS_READ = rdata_q;
  assign rd_valid      = rvalid_q;
  assign bus_err       = err_q;
  assign rd_count      = rd_cnt_q;
  assign wr_count      = wr_cnt_q;

endmodule
